// File: rtl/debounce_if.sv
// rtl/debounce_if.sv - raw input level and debounced outputs of the debounce block
interface debounce_if;
    logic a_i;
    logic debounced_o;
    logic change_o;
    logic busy_o;

    modport master (
        output a_i,
        input  debounced_o,
        input  change_o,
        input  busy_o
    );

    modport slave (
        input  a_i,
        output debounced_o,
        output change_o,
        output busy_o
    );
endinterface

// File: rtl/debounce.sv
// rtl/debounce.sv - two-state debouncer; DEBOUNCE_SYNC_EN adds a two-flop input synchronizer
// An input change must be sampled STABLE_CYCLES consecutive edges before debounced_o follows it.
module debounce #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    debounce_if.slave  bus
);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic             s;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc_d;
    logic             deb_q;
    logic             chg_q;
    logic             busy_q;
    logic             reach_d;
    logic             commit_d;

`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.a_i};
        end
    end

    assign s = sync_q[1];
`else
    assign s = bus.a_i;
`endif

    // This edge is the cnt_q+1-th consecutive one with s differing; cnt_q is 0 while STABLE.
    assign reach_d   = (32'(cnt_q) + 32'd1) >= 32'(STABLE_CYCLES);
    // A commit right after a pulse is deferred so change_o can never be high twice in a row.
    assign commit_d  = reach_d && !chg_q;
    assign cnt_inc_d = (cnt_q < CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
            chg_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            chg_q <= 1'b0;
            case (state_q)
                ST_STABLE: begin
                    if (s != deb_q) begin
                        if (commit_d) begin
                            deb_q  <= s;
                            chg_q  <= 1'b1;
                            cnt_q  <= '0;
                            busy_q <= 1'b0;
                        end else begin
                            state_q <= ST_PENDING;
                            cnt_q   <= CNT_W'(1);
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q  <= '0;
                        busy_q <= 1'b0;
                    end
                end
                ST_PENDING: begin
                    if (s == deb_q) begin
                        state_q <= ST_STABLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (commit_d) begin
                        state_q <= ST_STABLE;
                        deb_q   <= s;
                        chg_q   <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_inc_d;
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_STABLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.debounced_o = deb_q;
    assign bus.change_o    = chg_q;
    assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_debounce.sv
// tb/tb_debounce.sv - table-driven bench for debounce (STABLE_CYCLES=4 and STABLE_CYCLES=1)
module tb_debounce;

    localparam int N = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    debounce_if bus4 ();
    debounce_if bus1 ();

    debounce #(.STABLE_CYCLES(N)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    debounce #(.STABLE_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic a;
        logic deb;
        logic chg;
        logic busy;
    } vec_t;

    vec_t tbl[$];
    logic av[0:63];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic push(input logic r, input logic a, input logic d, input logic c, input logic b);
        vec_t v;
        v.rst = r; v.a = a; v.deb = d; v.chg = c; v.busy = b;
        tbl.push_back(v);
    endtask

    // a held at a new level for n edges: output flips on edge D+N, busy on edges D+1..D+N-1
    task automatic add_settle(input logic a, input logic old, input int n);
        for (int k = 1; k <= n; k++) begin
            if (k < D + N)       push(1'b0, a, old, 1'b0, k > D);
            else if (k == D + N) push(1'b0, a, a, 1'b1, 1'b0);
            else                 push(1'b0, a, a, 1'b0, 1'b0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic prev;
        logic s;
        int   pulses;
        int   last;

        bus4.a_i = 1'b1;
        bus1.a_i = 1'b0;
        tick();
        tick();
        check("reset_deb4", bus4.debounced_o, 1'b0);
        check("reset_chg4", bus4.change_o, 1'b0);
        check("reset_busy4", bus4.busy_o, 1'b0);
        check("reset_deb1", bus1.debounced_o, 1'b0);

        // reset held with a=1, then release: a=1 must still be qualified once
        push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add_settle(1'b1, 1'b0, D + N + 2);
        // falling change held 10 cycles
        add_settle(1'b0, 1'b1, 10);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // 3-cycle glitch is rejected
        for (int k = 1; k <= D + 5; k++)
            push(1'b0, k <= 3, 1'b0, 1'b0, (k > D) && (k <= D + 3));
        // toggle every 2 cycles for 20 cycles, then hold 1
        last = 20 + D + N + 1;
        for (int k = 1; k <= last; k++)
            av[k] = (k <= 20) ? (((k - 1) % 4) < 2) : 1'b1;
        for (int k = 1; k <= last; k++) begin
            s = (k > D) ? av[k - D] : 1'b0;
            push(1'b0, av[k], k >= 20 + D + N, k == 20 + D + N, s && (k < 20 + D + N));
        end

        foreach (tbl[i]) begin
            reset    = tbl[i].rst;
            bus4.a_i = tbl[i].a;
            tick();
            check($sformatf("vec%0d_deb", i), bus4.debounced_o, tbl[i].deb);
            check($sformatf("vec%0d_chg", i), bus4.change_o, tbl[i].chg);
            check($sformatf("vec%0d_busy", i), bus4.busy_o, tbl[i].busy);
        end

        // asynchronous clear of a set output
        #3 reset = 1'b1;
        #1;
        check("async_clr_deb", bus4.debounced_o, 1'b0);
        check("async_clr_chg", bus4.change_o, 1'b0);
        check("async_clr_busy", bus4.busy_o, 1'b0);
        bus4.a_i = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();

        // reset mid-PENDING at cnt=2 aborts the change
        bus4.a_i = 1'b1;
        repeat (D + 2) tick();
        check("abort_busy_before", bus4.busy_o, 1'b1);
        check("abort_deb_before", bus4.debounced_o, 1'b0);
        #3 reset = 1'b1;
        #1;
        check("abort_busy_async", bus4.busy_o, 1'b0);
        check("abort_deb_async", bus4.debounced_o, 1'b0);
        check("abort_chg_async", bus4.change_o, 1'b0);
        bus4.a_i = 1'b0;
        tick();
        reset = 1'b0;
        for (int k = 0; k < D + N + 3; k++) begin
            tick();
            check($sformatf("abort_after%0d_chg", k), bus4.change_o, 1'b0);
            check($sformatf("abort_after%0d_deb", k), bus4.debounced_o, 1'b0);
        end

        // STABLE_CYCLES=1 follows after D+1 edges
        bus1.a_i = 1'b1;
        for (int k = 1; k <= D + 1; k++) begin
            tick();
            check($sformatf("n1_step%0d_deb", k), bus1.debounced_o, k == D + 1);
            check($sformatf("n1_step%0d_chg", k), bus1.change_o, k == D + 1);
        end
        tick();
        check("n1_hold_deb", bus1.debounced_o, 1'b1);
        check("n1_hold_chg", bus1.change_o, 1'b0);

        // toggling every cycle: change_o never high two cycles running
        prev = bus1.change_o;
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            bus1.a_i = (k % 2) == 0;
            tick();
            check($sformatf("n1_tog%0d_no_double", k), bus1.change_o && prev, 1'b0);
            if (bus1.change_o) pulses++;
            prev = bus1.change_o;
        end
        check("n1_tog_some_pulse", pulses != 0, 1'b1);
        repeat (D + 3) tick();
        check("n1_final_deb", bus1.debounced_o, 1'b1);
        check("n1_final_chg", bus1.change_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debounce.md
DEBOUNCE -- requirements
Module: debounce

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: number of consecutive sampled cycles the input must hold a new value before the output follows; legal range 1..65535.
REQ-002 Parameter CNT_W, default $clog2(STABLE_CYCLES+1): stability counter width; the implementation SHALL NOT require the user to override it.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port a_i, input, 1: raw, possibly asynchronous and bouncing input level.
REQ-006 Port debounced_o, input-cleaned level, output, 1: registered; this is the level that feeds the downstream edge detector.
REQ-007 Port change_o, output, 1: registered one-cycle pulse in the cycle debounced_o takes a new value.
REQ-008 Port busy_o, output, 1: high while a candidate change is being qualified (state PENDING).

Function
REQ-009 The block SHALL derive an internal sample s from a_i (see Configuration).
REQ-010 The FSM SHALL have two states: STABLE (s == debounced_o) and PENDING (s != debounced_o, counting).
REQ-011 In STABLE: if s != debounced_o, go to PENDING with cnt = 1; otherwise cnt holds 0.
REQ-012 In PENDING: if s == debounced_o, go to STABLE with cnt = 0 and no output change (glitch rejected).
REQ-013 In PENDING: if s != debounced_o and cnt < STABLE_CYCLES, cnt increments by 1.
REQ-014 When s != debounced_o is sampled for the STABLE_CYCLES-th consecutive edge, debounced_o <= s, change_o <= 1, cnt <= 0, and the state becomes STABLE.
REQ-015 STABLE_CYCLES = 1 SHALL cause debounced_o to follow s after one sampled edge, with change_o still pulsed.
REQ-016 change_o SHALL be high for exactly one cycle per debounced_o transition and SHALL never be high for two consecutive cycles.
REQ-017 busy_o SHALL equal (state == PENDING) as a registered output.
REQ-018 cnt SHALL never exceed STABLE_CYCLES and SHALL never wrap.

Reset
REQ-019 On reset assertion, the synchronizer flops, debounced_o, change_o, busy_o and cnt SHALL clear to 0 immediately, and the state SHALL become STABLE.
REQ-020 Reset asserted mid-PENDING SHALL abort qualification; no change_o pulse SHALL be produced for the aborted change.
REQ-021 After reset deassertion, an a_i held at 1 SHALL be qualified like any other change, producing one rising debounced_o transition.

Configuration
REQ-022 With macro DEBOUNCE_SYNC_EN defined, s SHALL be the output of a two-flop synchronizer on a_i; debounced_o then changes on the (STABLE_CYCLES+2)-th rising clk edge after a_i settles.
REQ-023 With DEBOUNCE_SYNC_EN undefined, s SHALL be a_i directly (source already in clk domain); debounced_o then changes on the STABLE_CYCLES-th rising edge after a_i settles.

Verification
REQ-024 Scenario 1 (STABLE_CYCLES=4, sync on): reset with a_i=1, release, hold a_i=1 -> debounced_o=0 until the 6th edge after release, then 1; change_o high for exactly that one cycle.
REQ-025 Scenario 2: a_i stable 0, then a 3-cycle high glitch -> debounced_o stays 0; change_o never 1; busy_o high then returns to 0.
REQ-026 Scenario 3: debounced_o=1, then a_i=0 held for 10 cycles -> debounced_o falls 6 edges after the change; exactly one change_o pulse.
REQ-027 Scenario 4: reset asserted while busy_o=1 with cnt=2 -> all outputs 0 asynchronously; after release with a_i=0, no change_o pulse occurs.
REQ-028 Scenario 5: a_i toggles every 2 cycles for 20 cycles, then is held at 1 -> exactly one change_o pulse, occurring 6 edges after the final toggle.
REQ-029 Scenario 6 (DEBOUNCE_SYNC_EN undefined, STABLE_CYCLES=4): a step of a_i from 0 to 1 -> debounced_o=1 after the 4th edge; plus STABLE_CYCLES=1 -> debounced_o=1 after the 1st edge.
